store_buffer: RTL

- Posted-write buffer directly downstream of the store byte-mask/replication stage.
- Accepts already-formatted stores (replicated write data plus 4-bit byte enable) from the MEM stage, queues them in order, and drains them to the data memory port via a read/write/resp handshake.
- Lets the pipeline retire stores without waiting for memory.
- Flags loads that hit a pending store's word so the pipeline can stall, or forwards data when the optional feature is enabled.

---
 rtl/rv32_mem_pkg.sv | 18 +
 rtl/store_buffer_if.sv | 47 ++++
 rtl/store_buffer_match.sv | 34 +++
 rtl/store_buffer.sv | 130 +++++++++++++
 4 files changed

// File: rtl/rv32_mem_pkg.sv
// Shared data-memory types: store buffer entry, drain FSM states,
// and the full-word byte mask.
package rv32_mem_pkg;

  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } sb_entry_t;

  typedef enum logic {
    SB_IDLE,
    SB_WRITE
  } sb_state_t;

  localparam logic [3:0] MASK_WORD = 4'b1111;

endpackage

// File: rtl/store_buffer_if.sv
// Store buffer bus: MEM-stage store/load side and data memory write port.
// ld_fwd_data exists only when STORE_BUF_FWD_EN is defined.
interface store_buffer_if #(
  parameter int AW = 32
);

  logic          st_valid;
  logic          st_ready;
  logic [AW-1:0] st_addr;
  logic [31:0]   st_wdata;
  logic [3:0]    st_wmask;
  logic          ld_valid;
  logic [AW-1:0] ld_addr;
  logic          ld_conflict;
`ifdef STORE_BUF_FWD_EN
  logic [31:0]   ld_fwd_data;
`endif
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_byte_enable;
  logic          mem_resp;
  logic          empty;

  modport master (
    output st_valid, st_addr, st_wdata, st_wmask,
    output ld_valid, ld_addr, mem_resp,
    input  st_ready, ld_conflict, mem_write,
    input  mem_address, mem_wdata, mem_byte_enable,
    input  empty
`ifdef STORE_BUF_FWD_EN
    , input ld_fwd_data
`endif
  );

  modport slave (
    input  st_valid, st_addr, st_wdata, st_wmask,
    input  ld_valid, ld_addr, mem_resp,
    output st_ready, ld_conflict, mem_write,
    output mem_address, mem_wdata, mem_byte_enable,
    output empty
`ifdef STORE_BUF_FWD_EN
    , output ld_fwd_data
`endif
  );

endinterface

// File: rtl/store_buffer_match.sv
// Word-address compare of a load against all valid store buffer entries,
// with youngest-match selection scanning back from tail-1.
module store_buffer_match
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH)
) (
  input  sb_entry_t [DEPTH-1:0] i_entries,
  input  logic [DEPTH-1:0]      i_valid,
  input  logic [PW-1:0]         i_tail,
  input  logic [29:0]           i_waddr,
  output logic [DEPTH-1:0]      o_match,
  output logic [PW-1:0]         o_idx
);

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_match[i] = i_valid[i] &&
                   (i_entries[i].waddr == i_waddr);
    end
  end

  // oldest first, so the last hit written is the youngest
  always_comb begin
    o_idx = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (o_match[i_tail - PW'(k)]) begin
        o_idx = i_tail - PW'(k);
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer draining to data memory.
// STORE_BUF_FWD_EN adds full-word store-to-load forwarding.
module store_buffer
  import rv32_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  store_buffer_if.slave sb
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  sb_entry_t [DEPTH-1:0] r_mem;
  logic [DEPTH-1:0]      r_vld;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  logic [CW-1:0]         r_count;
  sb_state_t             r_state;

  sb_state_t             w_state_nxt;
  logic [CW-1:0]         w_cnt_nxt;
  logic [DEPTH-1:0]      w_vld_nxt;
  logic                  w_push;
  logic                  w_pop;
  sb_entry_t             w_new;
  sb_entry_t             w_head;
  logic [DEPTH-1:0]      w_match;
  logic [PW-1:0]         w_idx;
  logic                  w_hit;
  logic [29:0]           w_ld_waddr;
  logic                  w_unused;

  assign w_unused = ^{sb.st_addr[1:0], sb.ld_addr[1:0]};

  assign sb.st_ready = (r_count != CW'(DEPTH));

  // zero-mask stores are acknowledged but never queued
  assign w_push = sb.st_valid && sb.st_ready &&
                  (sb.st_wmask != 4'b0000);
  assign w_pop  = (r_state == SB_WRITE) && sb.mem_resp;

  assign w_new.waddr = 30'(sb.st_addr[AW-1:2]);
  assign w_new.wdata = sb.st_wdata;
  assign w_new.wmask = sb.st_wmask;

  always_comb begin
    w_cnt_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_cnt_nxt = r_count + CW'(1);
      2'b01:   w_cnt_nxt = r_count - CW'(1);
      default: w_cnt_nxt = r_count;
    endcase
  end

  always_comb begin
    w_vld_nxt = r_vld;
    if (w_pop)  w_vld_nxt[r_head] = 1'b0;
    if (w_push) w_vld_nxt[r_tail] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      SB_IDLE:
        if (r_count != '0) w_state_nxt = SB_WRITE;
      SB_WRITE:
        if (sb.mem_resp && (w_cnt_nxt == '0))
          w_state_nxt = SB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= SB_IDLE;
      r_count <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_vld   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_cnt_nxt;
      r_vld   <= w_vld_nxt;
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_tail] <= w_new;
  end

  assign w_head             = r_mem[r_head];
  assign sb.mem_write       = (r_state == SB_WRITE);
  assign sb.mem_address     = AW'({w_head.waddr, 2'b00});
  assign sb.mem_wdata       = w_head.wdata;
  assign sb.mem_byte_enable = w_head.wmask;
  assign sb.empty = (r_count == '0) && (r_state == SB_IDLE);

  assign w_ld_waddr = 30'(sb.ld_addr[AW-1:2]);

  store_buffer_match #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_match (
    .i_entries (r_mem),
    .i_valid   (r_vld),
    .i_tail    (r_tail),
    .i_waddr   (w_ld_waddr),
    .o_match   (w_match),
    .o_idx     (w_idx)
  );

  assign w_hit = |w_match;

`ifdef STORE_BUF_FWD_EN
  logic w_fwd;
  assign w_fwd = w_hit && (r_mem[w_idx].wmask == MASK_WORD);
  assign sb.ld_conflict = sb.ld_valid && w_hit && !w_fwd;
  assign sb.ld_fwd_data = w_fwd ? r_mem[w_idx].wdata : '0;
`else
  logic w_idx_unused;
  assign w_idx_unused = ^w_idx;
  assign sb.ld_conflict = sb.ld_valid && w_hit;
`endif

endmodule
